// File: rtl/arith_cmd_sequencer_pkg.sv
// rtl/arith_cmd_sequencer_pkg.sv - shared types and helpers for the arithmetic command sequencer
package arith_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_GET_A,
    ST_GET_B,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    FUN_ADD = 2'b00,
    FUN_SUB = 2'b01,
    FUN_MUL = 2'b10,
    FUN_DIV = 2'b11
  } fun_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  // Counter width that still works when only one value has to be held.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arith_cmd_sequencer_if.sv
// rtl/arith_cmd_sequencer_if.sv - command stream, arithmetic unit and response signals
interface arith_cmd_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;

  logic [WIDTH-1:0] arith_a;
  logic [WIDTH-1:0] arith_b;
  logic [1:0]       arith_fun;
  logic             arith_enable;
  logic [WIDTH-1:0] arith_out;
  logic             arith_carry;
  logic             arith_flag;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic [1:0]       res_err;

  modport master (
    input  in_valid, in_data, arith_out, arith_carry, arith_flag, res_ready,
    output in_ready, arith_a, arith_b, arith_fun, arith_enable,
           res_valid, res_data, res_carry, res_err
  );

  modport slave (
    output in_valid, in_data, arith_out, arith_carry, arith_flag, res_ready,
    input  in_ready, arith_a, arith_b, arith_fun, arith_enable,
           res_valid, res_data, res_carry, res_err
  );

endinterface

// File: rtl/arith_byte_deser.sv
// rtl/arith_byte_deser.sv - MSB-first byte to operand deserialiser with wrapping byte counter
module arith_byte_deser
  import arith_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [7:0]       i_data,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = cnt_width(NBYTES);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;

  assign o_last = (r_cnt == CW'(NBYTES - 1));
  assign o_word = r_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_en) begin
      r_word <= (r_word << 8) | WIDTH'(i_data);
      r_cnt  <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arith_cmd_sequencer.sv
// rtl/arith_cmd_sequencer.sv - collects a command frame, issues it to an arithmetic unit and holds the result
module arith_cmd_sequencer
  import arith_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4
) (
  input logic                 clk,
  input logic                 rst,
  arith_cmd_sequencer_if.master bus
);

  localparam int TW = cnt_width(TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  fun_t             r_fun;
  logic [TW-1:0]    r_wait;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_carry;
  err_t             r_res_err;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_a_last;
  logic             w_b_last;
  logic             w_in_ready;
  logic             w_enable;
  logic             w_accept;
  logic             w_div0;
  logic             w_expired;

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_div0    = (r_fun == FUN_DIV) && (w_b == '0);
  assign w_expired = (r_wait == TW'(TIMEOUT - 1));

  arith_byte_deser #(.WIDTH(WIDTH)) u_deser_a (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept && (r_state == ST_GET_A)),
    .i_data (bus.in_data),
    .o_word (w_a),
    .o_last (w_a_last)
  );

  arith_byte_deser #(.WIDTH(WIDTH)) u_deser_b (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept && (r_state == ST_GET_B)),
    .i_data (bus.in_data),
    .o_word (w_b),
    .o_last (w_b_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HDR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_enable   = 1'b0;
    case (r_state)
      ST_HDR: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_GET_A;
      end
      ST_GET_A: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_a_last) w_next = ST_GET_B;
      end
      ST_GET_B: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_b_last) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_div0) begin
          w_next = ST_RESP;
        end else begin
          w_enable = 1'b1;
          w_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.arith_flag || w_expired) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.res_ready) w_next = ST_HDR;
      end
      default: w_next = ST_HDR;
    endcase
  end

  // Result registers only change on ISSUE/WAIT, so they stay put for the whole RESP hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fun       <= FUN_ADD;
      r_wait      <= '0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_err   <= ERR_OK;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (w_accept) r_fun <= fun_t'(bus.in_data[1:0]);
        end
        ST_ISSUE: begin
          r_wait <= '0;
          if (w_div0) begin
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_err   <= ERR_DIV0;
          end
        end
        ST_WAIT: begin
          if (bus.arith_flag) begin
            r_res_data  <= bus.arith_out;
            r_res_carry <= bus.arith_carry;
            r_res_err   <= ERR_OK;
          end else if (w_expired) begin
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_err   <= ERR_TIMEOUT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready && !rst;
  assign bus.arith_enable = w_enable && !rst;
  assign bus.arith_a      = w_a;
  assign bus.arith_b      = w_b;
  assign bus.arith_fun    = r_fun;
  assign bus.res_valid    = (r_state == ST_RESP);
  assign bus.res_data     = r_res_data;
  assign bus.res_carry    = r_res_carry;
  assign bus.res_err      = r_res_err;

endmodule

// File: tb/tb_arith_cmd_sequencer.sv
// tb/tb_arith_cmd_sequencer.sv - scoreboard bench for arith_cmd_sequencer with a behavioural arithmetic unit
module tb_arith_cmd_sequencer;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic         carry;
    logic [1:0]   err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arith_cmd_sequencer_if #(.WIDTH(W)) bus ();

  arith_cmd_sequencer #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  resp_t sb[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  int       flag_delay = 1;
  bit       flag_never = 1'b0;
  logic     stray_flag = 1'b0;
  logic     m_flag;
  logic     m_carry;
  logic [W-1:0] m_out;
  int       m_cnt;
  int       n_strobes = 0;

  assign bus.arith_out   = m_out;
  assign bus.arith_carry = m_carry;
  assign bus.arith_flag  = m_flag | stray_flag;

  function automatic logic [W:0] calc(input logic [1:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (fun)
      2'b00: return {1'b0, a} + {1'b0, b};
      2'b01: return {1'b0, a} - {1'b0, b};
      2'b10: begin
        p = a * b;
        return {|p[2*W-1:W], p[W-1:0]};
      end
      default: return {1'b0, (b == '0) ? {W{1'b0}} : a / b};
    endcase
  endfunction

  // Registered arithmetic unit: results latch on the strobe, flag follows flag_delay cycles later.
  always @(posedge clk) begin
    if (rst) begin
      m_flag  <= 1'b0;
      m_cnt   <= 0;
      m_out   <= '0;
      m_carry <= 1'b0;
    end else begin
      m_flag <= 1'b0;
      if (bus.arith_enable) begin
        {m_carry, m_out} <= calc(bus.arith_fun, bus.arith_a, bus.arith_b);
        n_strobes <= n_strobes + 1;
        if (!flag_never) begin
          if (flag_delay <= 1) m_flag <= 1'b1;
          else                 m_cnt  <= flag_delay - 1;
        end
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_flag <= 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [W-1:0] a, input logic [W-1:0] b);
    send_byte(h);
    for (int i = W/8 - 1; i >= 0; i--) send_byte(a[i*8 +: 8]);
    for (int i = W/8 - 1; i >= 0; i--) send_byte(b[i*8 +: 8]);
  endtask

  task automatic get_resp(output resp_t r, output int lat, output bit got);
    lat = 0;
    @(negedge clk);
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = bus.res_valid;
    r   = {bus.res_data, bus.res_carry, bus.res_err};
    if (got) begin
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready);
    end
    tests_run++;
    if ({bus.res_valid, bus.res_data, bus.res_carry, bus.res_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_resp: got valid=%b data=%h carry=%b err=%b, expected all 0",
               bus.res_valid, bus.res_data, bus.res_carry, bus.res_err);
    end
    tests_run++;
    if ({bus.arith_enable, bus.arith_a, bus.arith_b, bus.arith_fun} !== '0) begin
      tests_failed++;
      $display("FAIL reset_arith: got en=%b a=%h b=%h fun=%b, expected all 0",
               bus.arith_enable, bus.arith_a, bus.arith_b, bus.arith_fun);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_add();
    resp_t r, e;
    int    lat;
    bit    got;
    sb.push_back('{data: 16'h1235, carry: 1'b0, err: 2'b00});
    send_frame(8'h00, 16'h1234, 16'h0001);
    get_resp(r, lat, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || r !== e) begin
      tests_failed++;
      $display("FAIL add_resp: got valid=%b %h/%b/%b, expected %h/%b/%b", got, r.data, r.carry, r.err, e.data, e.carry, e.err);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL add_latency: got %0d cycles after last byte, expected 2", lat);
    end
  endtask

  task automatic test_sub();
    resp_t r, e;
    int    lat, s0;
    bit    got;
    s0 = n_strobes;
    sb.push_back('{data: 16'hFFFF, carry: 1'b1, err: 2'b00});
    send_frame(8'h01, 16'h0000, 16'h0001);
    get_resp(r, lat, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || r !== e) begin
      tests_failed++;
      $display("FAIL sub_resp: got valid=%b %h/%b/%b, expected %h/%b/%b", got, r.data, r.carry, r.err, e.data, e.carry, e.err);
    end
    tests_run++;
    if (n_strobes - s0 !== 1) begin
      tests_failed++;
      $display("FAIL sub_strobes: got %0d enable pulses, expected 1", n_strobes - s0);
    end
  endtask

  task automatic test_div0();
    resp_t r, e;
    int    lat, s0;
    bit    got;
    s0 = n_strobes;
    sb.push_back('{data: 16'h0000, carry: 1'b0, err: 2'b01});
    send_frame(8'h03, 16'h0010, 16'h0000);
    get_resp(r, lat, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || r !== e) begin
      tests_failed++;
      $display("FAIL div0_resp: got valid=%b %h/%b/%b, expected %h/%b/%b", got, r.data, r.carry, r.err, e.data, e.carry, e.err);
    end
    tests_run++;
    if (n_strobes != s0 || lat !== 1) begin
      tests_failed++;
      $display("FAIL div0_no_issue: got %0d pulses latency %0d, expected 0 pulses latency 1", n_strobes - s0, lat);
    end
  endtask

  task automatic test_timeout();
    resp_t r, e;
    int    lat;
    bit    got;
    flag_never = 1'b1;
    sb.push_back('{data: 16'h0000, carry: 1'b0, err: 2'b10});
    send_frame(8'h02, 16'h0003, 16'h0004);
    get_resp(r, lat, got);
    e = sb.pop_front();
    flag_never = 1'b0;
    tests_run++;
    if (!got || r !== e) begin
      tests_failed++;
      $display("FAIL timeout_resp: got valid=%b %h/%b/%b, expected %h/%b/%b", got, r.data, r.carry, r.err, e.data, e.carry, e.err);
    end
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL timeout_cycles: got latency %0d, expected 5 (ISSUE + 4 WAIT)", lat);
    end
  endtask

  task automatic test_hold();
    resp_t e;
    int    n;
    sb.push_back('{data: 16'h000C, carry: 1'b0, err: 2'b00});
    send_frame(8'hFE, 16'h0003, 16'h0004);
    e = sb.pop_front();
    n = 0;
    @(negedge clk);
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== e.data || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got valid=%b data=%h in_ready=%b, expected 1 %h 0",
                 i, bus.res_valid, bus.res_data, bus.in_ready, e.data);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({bus.res_carry, bus.res_err} !== {e.carry, e.err}) begin
      tests_failed++;
      $display("FAIL hold_flags: got carry=%b err=%b, expected %b %b", bus.res_carry, bus.res_err, e.carry, e.err);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_release: got valid=%b in_ready=%b, expected 0 1", bus.res_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    resp_t r, e;
    int    lat;
    bit    got;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back('{data: 16'h0002, carry: 1'b0, err: 2'b00});
    send_frame(8'h00, 16'h0001, 16'h0001);
    get_resp(r, lat, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || r !== e) begin
      tests_failed++;
      $display("FAIL reset_mid_resp: got valid=%b %h/%b/%b, expected %h/%b/%b", got, r.data, r.carry, r.err, e.data, e.carry, e.err);
    end
    // Reset while a response is waiting must drop it.
    send_frame(8'h00, 16'h1111, 16'h2222);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_resp_drop: got valid=%b in_ready=%b data=%h, expected 0 1 0000",
               bus.res_valid, bus.in_ready, bus.res_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle_noise();
    resp_t r, e;
    int    lat;
    bit    got, bad;
    stray_flag    = 1'b1;
    bus.res_ready = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL idle_noise: got valid=%b in_ready=%b, expected 0 1", bus.res_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    stray_flag    = 1'b0;
    bus.res_ready = 1'b0;
    flag_delay    = 3;
    sb.push_back('{data: 16'h0000, carry: 1'b1, err: 2'b00});
    send_frame(8'h00, 16'hFFFF, 16'h0001);
    get_resp(r, lat, got);
    e = sb.pop_front();
    flag_delay = 1;
    tests_run++;
    if (!got || r !== e || lat !== 4) begin
      tests_failed++;
      $display("FAIL late_flag: got valid=%b %h/%b/%b lat=%0d, expected %h/%b/%b lat=4",
               got, r.data, r.carry, r.err, lat, e.data, e.carry, e.err);
    end
  endtask

  task automatic test_back_to_back();
    resp_t r, e;
    int    lat;
    bit    got;
    logic [1:0]   fun;
    logic [W-1:0] a, b;
    logic [W:0]   m;
    for (int k = 0; k < 8; k++) begin
      fun = 2'($urandom_range(0, 3));
      a   = W'($urandom);
      b   = (k == 5) ? '0 : W'($urandom);
      if (fun == 2'b11 && b == '0) begin
        sb.push_back('{data: '0, carry: 1'b0, err: 2'b01});
      end else begin
        m = calc(fun, a, b);
        sb.push_back('{data: m[W-1:0], carry: m[W], err: 2'b00});
      end
      send_frame({6'($urandom), fun}, a, b);
      get_resp(r, lat, got);
      e = sb.pop_front();
      tests_run++;
      if (!got || r !== e) begin
        tests_failed++;
        $display("FAIL b2b_%0d fun=%b a=%h b=%h: got valid=%b %h/%b/%b, expected %h/%b/%b",
                 k, fun, a, b, got, r.data, r.carry, r.err, e.data, e.carry, e.err);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_div0();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_idle_noise();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
